// File: rtl/hazard_pkg.sv
// Shared types and encodings for the ID-stage issue/hazard controller.
// Opcode/funct values, scoreboard entry and instruction class bundles.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_entry_t;

  typedef struct packed {
    logic       has_dest;
    logic [4:0] dest;
    logic       reads_rs;
    logic       reads_rt;
    logic       is_load;
    logic       is_muldiv;
    logic       is_mfhilo;
  } insn_class_t;

  // True when a live in-flight producer writes a register the ID insn reads.
  function automatic logic src_hit(
    input sb_entry_t   e,
    input insn_class_t c,
    input logic [4:0]  rs,
    input logic [4:0]  rt
  );
    return e.valid &
      ((c.reads_rs & (rs == e.dest)) |
       (c.reads_rt & (rt == e.dest)));
  endfunction

endpackage

// File: rtl/issue_classifier.sv
// Combinational decode of the IF/ID instruction into dest/source usage.
// Register 0 as a destination is treated as no destination.
module issue_classifier
  import hazard_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output insn_class_t cls
);

  insn_class_t c;

  // Per-opcode dest/read classification, then squash writes to $0.
  always_comb begin
    c = '0;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        c.has_dest = 1'b1;
        c.dest     = rd;
        c.reads_rs = 1'b1;
        c.reads_rt = 1'b1;
        if (funct == FN_SLL || funct == FN_SRL ||
            funct == FN_SRA) begin
          c.reads_rs = 1'b0;
        end else if (funct == FN_MULT || funct == FN_MULTU ||
                     funct == FN_DIV  || funct == FN_DIVU) begin
          c.has_dest  = 1'b0;
          c.is_muldiv = 1'b1;
        end else if (funct == FN_JR) begin
          c.has_dest = 1'b0;
        end else if (funct == FN_MFHI || funct == FN_MFLO) begin
          c.reads_rs  = 1'b0;
          c.reads_rt  = 1'b0;
          c.is_mfhilo = 1'b1;
        end
      end
      (opcode == OP_LW): begin
        c.has_dest = 1'b1;
        c.dest     = rt;
        c.reads_rs = 1'b1;
        c.is_load  = 1'b1;
      end
      (opcode == OP_ADDI || opcode == OP_ADDIU ||
       opcode == OP_SLTI || opcode == OP_ANDI ||
       opcode == OP_ORI): begin
        c.has_dest = 1'b1;
        c.dest     = rt;
        c.reads_rs = 1'b1;
      end
      (opcode == OP_LUI): begin
        c.has_dest = 1'b1;
        c.dest     = rt;
      end
      (opcode == OP_SW || opcode == OP_BEQ ||
       opcode == OP_BNE): begin
        c.reads_rs = 1'b1;
        c.reads_rt = 1'b1;
      end
      (opcode == OP_JAL): begin
        c.has_dest = 1'b1;
        c.dest     = 5'd31;
      end
      (opcode == OP_J): begin
        c = '0;
      end
      default: begin
        c = '0;
      end
    endcase
    if (c.dest == 5'd0) begin
      c.has_dest = 1'b0;
    end
  end

  assign cls = c;

endmodule

// File: rtl/issue_hazard_ctrl.sv
// ID-stage issue control: scoreboard over EX/MEM/WB plus mult/div busy.
// ISSUE_FORWARDING_EN: only load-use in EX stalls; else any live match.
module issue_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [15:0] stall_count
);

  localparam logic [3:0] LAT = 4'(MULDIV_LAT);

  insn_class_t cls;
  sb_entry_t   ex_q, mem_q, wb_q, ex_d;
  logic [3:0]  busy_q, busy_d;
  logic [15:0] stall_q, stall_d;
  logic        data_hz, md_hz, hazard, issue;

  issue_classifier u_cls (
    .opcode (opcode),
    .funct  (funct),
    .rt     (rt),
    .rd     (rd),
    .cls    (cls)
  );

  // Hazard detection against the in-flight producers and HI/LO.
  always_comb begin
`ifdef ISSUE_FORWARDING_EN
    data_hz = ex_q.is_load & src_hit(ex_q, cls, rs, rt);
`else
    data_hz = src_hit(ex_q, cls, rs, rt) |
              src_hit(mem_q, cls, rs, rt) |
              src_hit(wb_q, cls, rs, rt);
`endif
    md_hz  = (busy_q != 4'd0) & (cls.is_muldiv | cls.is_mfhilo);
    hazard = id_valid & (data_hz | md_hz);
    issue  = id_valid & ~hazard & ~branch_taken;
  end

  // Pipeline control, reset first, then flush, then stall.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = ~id_valid;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Next-state for the EX entry, busy counter and stall counter.
  always_comb begin
    ex_d.valid   = issue & cls.has_dest;
    ex_d.dest    = cls.dest;
    ex_d.is_load = cls.is_load;
    busy_d = busy_q;
    if (issue && cls.is_muldiv) begin
      busy_d = LAT;
    end else if (busy_q != 4'd0) begin
      busy_d = busy_q - 4'd1;
    end
    stall_d = stall_q;
    if (hazard && !branch_taken && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Directed vector bench for issue_hazard_ctrl.
// Expected stall counts depend on ISSUE_FORWARDING_EN.
module tb_issue_hazard_ctrl;

  localparam logic [5:0] R = 6'h00, LW = 6'h23, ADDI = 6'h08;
  localparam logic [5:0] ADD = 6'h20, MULT = 6'h18, MFLO = 6'h12;
`ifdef ISSUE_FORWARDING_EN
  localparam int LU = 1, RAW = 0;
`else
  localparam int LU = 3, RAW = 3;
`endif

  typedef struct {
    logic        rst, vld;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic        br;
    logic        pc, ifw, fl, bub;
    logic [15:0] cnt;
  } vec_t;

  logic        clock = 0, reset = 1, id_valid = 0, branch_taken = 0;
  logic [5:0]  opcode = 0, funct = 0;
  logic [4:0]  rs = 0, rt = 0, rd = 0;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [15:0] stall_count;

  vec_t tv[$];
  int   mcnt = 0;
  int   n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  issue_hazard_ctrl #(.MULDIV_LAT(4)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .branch_taken(branch_taken), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .stall_count(stall_count)
  );

  // kind: 0 normal, 1 stall, 2 flush, 3 reset
  task automatic push(input logic rst, input logic vld,
                      input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic br,
                      input int kind);
    vec_t v;
    v.rst = rst; v.vld = vld; v.op = op; v.fn = fn;
    v.rs = s; v.rt = t; v.rd = d; v.br = br;
    v.cnt = 16'(mcnt);
    case (kind)
      1:       begin v.pc = 0; v.ifw = 0; v.fl = 0; v.bub = 1; end
      2:       begin v.pc = 1; v.ifw = 1; v.fl = 1; v.bub = 1; end
      3:       begin v.pc = 0; v.ifw = 0; v.fl = 1; v.bub = 1; end
      default: begin v.pc = 1; v.ifw = 1; v.fl = 0; v.bub = !vld; end
    endcase
    if (kind == 1) mcnt++;
    if (kind == 3) mcnt = 0;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input int i,
                     input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0h want %0h", nm, i, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; id_valid = v.vld; opcode = v.op; funct = v.fn;
    rs = v.rs; rt = v.rt; rd = v.rd; branch_taken = v.br;
  endtask

  initial begin
    int st, k;
    logic [15:0] c0;
    push(1, 0, 0, 0, 0, 0, 0, 0, 3);
    push(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(0, 1, LW, 0, 9, 8, 0, 0, 0);
    for (int i = 0; i < LU; i++) push(0, 1, R, ADD, 8, 11, 10, 0, 1);
    push(0, 1, R, ADD, 8, 11, 10, 0, 0);
    push(0, 1, ADDI, 0, 0, 8, 0, 0, 0);
    for (int i = 0; i < RAW; i++) push(0, 1, R, ADD, 8, 8, 10, 0, 1);
    push(0, 1, R, ADD, 8, 8, 10, 0, 0);
    push(0, 1, R, MULT, 4, 5, 0, 0, 0);
    for (int i = 0; i < 4; i++) push(0, 1, R, MFLO, 0, 0, 6, 0, 1);
    push(0, 1, R, MFLO, 0, 0, 6, 0, 0);
    push(0, 1, R, MULT, 2, 3, 0, 0, 0);
    for (int i = 0; i < 4; i++) push(0, 1, R, MULT, 4, 5, 0, 0, 1);
    push(0, 1, R, MULT, 4, 5, 0, 0, 0);
    for (int i = 0; i < 5; i++) push(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(0, 1, LW, 0, 9, 8, 0, 0, 0);
    push(0, 1, R, ADD, 8, 11, 10, 0, 1);
    push(0, 1, R, ADD, 8, 11, 10, 1, 2);
    push(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(0, 1, R, MULT, 4, 5, 0, 1, 2);
    push(0, 1, R, MFLO, 0, 0, 6, 0, 0);
    push(0, 1, R, ADD, 8, 9, 0, 0, 0);
    push(0, 1, R, ADD, 0, 0, 10, 0, 0);
    push(0, 1, LW, 0, 9, 8, 0, 0, 0);
    push(0, 1, R, ADD, 8, 11, 10, 0, 1);
    push(1, 1, R, ADD, 8, 11, 10, 0, 3);
    push(0, 1, R, ADD, 8, 11, 10, 0, 0);

    reset = 1;
    repeat (2) @(posedge clock);
    foreach (tv[i]) begin
      @(negedge clock);
      drive(tv[i]);
      #3;
      chk("pc_write",    i, 16'(pc_write),    16'(tv[i].pc));
      chk("ifid_write",  i, 16'(ifid_write),  16'(tv[i].ifw));
      chk("ifid_flush",  i, 16'(ifid_flush),  16'(tv[i].fl));
      chk("idex_bubble", i, 16'(idex_bubble), 16'(tv[i].bub));
      chk("stall_count", i, stall_count,      tv[i].cnt);
    end

    // mult then mflo: count stall cycles until mflo issues
    @(negedge clock);
    reset = 0; branch_taken = 0; id_valid = 1;
    opcode = R; funct = MULT; rs = 4; rt = 5; rd = 0;
    #3;
    c0 = stall_count;
    chk("mult_issue", 0, 16'(pc_write), 16'd1);
    @(negedge clock);
    funct = MFLO; rs = 0; rt = 0; rd = 6;
    #3;
    st = 0; k = 0;
    while (!pc_write && k < 20) begin
      st++; k++;
      @(negedge clock);
      #3;
    end
    chk("mflo_stalls", 0, 16'(st), 16'd4);
    chk("mflo_cnt", 0, stall_count, c0 + 16'd4);
    chk("mflo_bubble", 0, 16'(idex_bubble), 16'd0);

    @(negedge clock);
    id_valid = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
